// File: rtl/store_pkg.sv
// Shared definitions for the store formatting path: size encodings,
// byte-enable constants and the buffered store entry layout.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Widest supported address; the top's AW must not exceed this.
    localparam int STORE_AW = 32;

    typedef struct packed {
        logic [STORE_AW-1:0] addr;
        logic [31:0]         data;
        logic [3:0]          be;
    } store_entry_t;

endpackage

// File: rtl/store_lane_format.sv
// Combinational lane placement: replicates the narrowed register value across
// the word and selects byte enables from the low address bits and access size.
module store_lane_format
    import store_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [3:0]  be,
    output logic        illegal,
    output logic        misaligned
);

    // Replication means any lane chosen by the enables already carries the value.
    always_comb begin
        data_out   = data_in;
        be         = BE_WORD;
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                data_out = {4{data_in[7:0]}};
                be       = BE_BYTE << addr_lo;
            end
            SZ_HALF: begin
                data_out   = {2{data_in[15:0]}};
                be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                misaligned = addr_lo[0];
            end
            SZ_WORD: begin
                misaligned = (addr_lo != 2'b00);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_data_formatter.sv
// Formats MEM-stage stores onto byte lanes and buffers them in a small FIFO
// towards data memory. Define STORE_MISALIGN_TRAP_EN to drop misaligned stores.
module store_data_formatter
    import store_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AW-1:0]          req_addr_i,
    input  logic [31:0]            req_data_i,
    input  logic [1:0]             req_size_i,
    output logic                   mem_valid_o,
    input  logic                   mem_ready_i,
    output logic [AW-1:0]          mem_addr_o,
    output logic [31:0]            mem_data_o,
    output logic [3:0]             mem_be_o,
    output logic                   err_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   fmt_data;
    logic [3:0]    fmt_be;
    logic          fmt_illegal;
    logic          fmt_misaligned;
    logic          accept;
    logic          drop;
    logic          push;
    logic          pop;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          err_q;
    store_entry_t  fifo_q [DEPTH];
    store_entry_t  head;

    store_lane_format u_fmt (
        .addr_lo    (req_addr_i[1:0]),
        .size       (req_size_i),
        .data_in    (req_data_i),
        .data_out   (fmt_data),
        .be         (fmt_be),
        .illegal    (fmt_illegal),
        .misaligned (fmt_misaligned)
    );

`ifdef STORE_MISALIGN_TRAP_EN
    assign drop = fmt_illegal || fmt_misaligned;
`else
    // Without trapping, the formatter's lane choice already ignores the stray low bits.
    logic unused_misaligned;
    assign unused_misaligned = fmt_misaligned;
    assign drop = fmt_illegal;
`endif

    assign req_ready_o = (count_q != FULL);
    assign mem_valid_o = (count_q != '0);
    assign accept      = req_valid_i && req_ready_o;
    assign push        = accept && !drop;
    assign pop         = mem_valid_o && mem_ready_i;

    assign head       = fifo_q[rd_ptr];
    assign mem_addr_o = mem_valid_o ? head.addr[AW-1:0] : '0;
    assign mem_data_o = mem_valid_o ? head.data : '0;
    assign mem_be_o   = mem_valid_o ? head.be : '0;
    assign err_o      = err_q;
    assign count_o    = count_q;

    // Pointers, occupancy and the error pulse; dropped requests still consume the handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && drop;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset; outputs are masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr] <= '{addr: STORE_AW'({req_addr_i[AW-1:2], 2'b00}),
                                data: fmt_data,
                                be:   fmt_be};
        end
    end

endmodule

// File: tb/tb_store_data_formatter.sv
// Directed and randomised checks of store_data_formatter against a scoreboard
// of lane-formatted stores; the model honours STORE_MISALIGN_TRAP_EN as well.
module tb_store_data_formatter;

    localparam int DEPTH = 2;
    localparam int AW    = 32;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [AW-1:0]          req_addr_i;
    logic [31:0]            req_data_i;
    logic [1:0]             req_size_i;
    logic                   mem_valid_o;
    logic                   mem_ready_i;
    logic [AW-1:0]          mem_addr_o;
    logic [31:0]            mem_data_o;
    logic [3:0]             mem_be_o;
    logic                   err_o;
    logic [$clog2(DEPTH):0] count_o;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    store_data_formatter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_size_i  (req_size_i),
        .mem_valid_o (mem_valid_o),
        .mem_ready_i (mem_ready_i),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_be_o    (mem_be_o),
        .err_o       (err_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference formatting: returns 1 when the store should reach memory.
    function automatic logic modelFormat(input logic [31:0] addr, input logic [31:0] data,
                                         input logic [1:0] size, output exp_t e);
        logic [1:0] a;
        a      = addr[1:0];
        e.addr = {addr[31:2], 2'b00};
        e.data = data;
        e.be   = 4'b1111;
        case (size)
            2'b00: begin
                e.data = {data[7:0], data[7:0], data[7:0], data[7:0]};
                e.be   = 4'b0001 << a;
            end
            2'b01: begin
                e.data = {data[15:0], data[15:0]};
                e.be   = a[1] ? 4'b1100 : 4'b0011;
`ifdef STORE_MISALIGN_TRAP_EN
                if (a[0]) return 1'b0;
`endif
            end
            2'b10: begin
`ifdef STORE_MISALIGN_TRAP_EN
                if (a != 2'b00) return 1'b0;
`endif
            end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [1:0] size, output int waits);
        exp_t e;
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_data_i  = data;
        req_size_i  = size;
        waits       = 0;
        @(negedge clk_i);
        while (!req_ready_o && waits < 50) begin
            @(negedge clk_i);
            waits++;
        end
        checkOutput("req_ready", req_ready_o, 1);
        if (modelFormat(addr, data, size, e)) sb.push_back(e);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (count_o != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("drain_count", count_o, 0);
        checkOutput("sb_empty", sb.size(), 0);
    endtask

    // Scoreboard side: every accepted head must match the oldest expected store.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (!rst_i && mem_valid_o && mem_ready_i) begin
            checkOutput("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("mem_addr", mem_addr_o, e.addr);
                checkOutput("mem_data", mem_data_o, e.data);
                checkOutput("mem_be", mem_be_o, e.be);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin : stimulus
        int   waits;
        exp_t e;
        logic enq;
        logic [31:0] tbl_addr [7];
        logic [31:0] tbl_data [7];
        logic [1:0]  tbl_size [7];
        logic [31:0] mis_addr [3];
        logic [1:0]  mis_size [3];

        tbl_addr = '{32'h2002, 32'h3000, 32'h0010, 32'h0011, 32'h0012, 32'h0013, 32'h2000};
        tbl_data = '{32'h12345678, 32'hCAFEF00D, 32'h11223344, 32'h55667788,
                     32'h99AABBCC, 32'hDEADBEEF, 32'hA5A55A5A};
        tbl_size = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        mis_addr = '{32'h4001, 32'h2001, 32'h4002};
        mis_size = '{2'b10, 2'b01, 2'b10};

        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_data_i  = '0;
        req_size_i  = 2'b00;
        mem_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_count", count_o, 0);
        checkOutput("rst_valid", mem_valid_o, 0);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_ready", req_ready_o, 1);
        checkOutput("rst_addr", mem_addr_o, 0);
        checkOutput("rst_data", mem_data_o, 0);
        checkOutput("rst_be", mem_be_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Byte store to the top lane, visible one cycle after acceptance.
        mem_ready_i = 1'b1;
        applyStimulus(32'h1003, 32'hAABBCCDD, 2'b00, waits);
        @(negedge clk_i);
        checkOutput("byte_valid", mem_valid_o, 1);
        checkOutput("byte_count", count_o, 1);
        checkOutput("byte_addr", mem_addr_o, 32'h1000);
        checkOutput("byte_data", mem_data_o, 32'hDDDDDDDD);
        checkOutput("byte_be", mem_be_o, 4'b1000);
        @(negedge clk_i);
        checkOutput("byte_count_after", count_o, 0);
        checkOutput("empty_data", mem_data_o, 0);
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 7; i++) applyStimulus(tbl_addr[i], tbl_data[i], tbl_size[i], waits);
        waitDrain();

        // Backpressure: two fill the FIFO, the third waits for a pop.
        @(posedge clk_i);
        #1;
        mem_ready_i = 1'b0;
        applyStimulus(32'h6000, 32'h01010101, 2'b10, waits);
        applyStimulus(32'h6004, 32'h02020202, 2'b10, waits);
        req_valid_i = 1'b1;
        req_addr_i  = 32'h6008;
        req_data_i  = 32'h03030303;
        req_size_i  = 2'b10;
        @(negedge clk_i);
        checkOutput("full_ready", req_ready_o, 0);
        checkOutput("full_count", count_o, 2);
        checkOutput("full_head_addr", mem_addr_o, 32'h6000);
        @(posedge clk_i);
        #1;
        checkOutput("full_hold_count", count_o, 2);
        mem_ready_i = 1'b1;
        applyStimulus(32'h6008, 32'h03030303, 2'b10, waits);
        checkOutput("third_wait", waits, 1);
        waitDrain();

        // Illegal size: accepted, dropped, single-cycle error.
        applyStimulus(32'h5000, 32'h77777777, 2'b11, waits);
        @(negedge clk_i);
        checkOutput("ill_err", err_o, 1);
        checkOutput("ill_count", count_o, 0);
        checkOutput("ill_valid", mem_valid_o, 0);
        @(negedge clk_i);
        checkOutput("ill_err_clear", err_o, 0);
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 3; i++) begin
            enq = modelFormat(mis_addr[i], 32'h0BADBEEF, mis_size[i], e);
            applyStimulus(mis_addr[i], 32'h0BADBEEF, mis_size[i], waits);
            @(negedge clk_i);
            checkOutput("mis_err", err_o, !enq);
            checkOutput("mis_valid", mem_valid_o, enq);
            @(posedge clk_i);
            #1;
            waitDrain();
        end

        // Reset with two held entries discards them.
        @(posedge clk_i);
        #1;
        mem_ready_i = 1'b0;
        applyStimulus(32'h7000, 32'h11111111, 2'b10, waits);
        applyStimulus(32'h7004, 32'h22222222, 2'b10, waits);
        @(negedge clk_i);
        checkOutput("pre_rst_count", count_o, 2);
        rst_i = 1'b1;
        sb.delete();
        @(negedge clk_i);
        checkOutput("mid_rst_valid", mem_valid_o, 0);
        checkOutput("mid_rst_count", count_o, 0);
        checkOutput("mid_rst_ready", req_ready_o, 1);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 24; i++) begin
            mem_ready_i = (count_o == DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            applyStimulus($urandom, $urandom, 2'($urandom_range(0, 3)), waits);
        end
        mem_ready_i = 1'b1;
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
